// File: rtl/systolic_ctrl.sv
// Sequencing controller for an N x N weight-stationary systolic array:
// loads weight rows, streams activations, writes results, then pulses done.
`timescale 1ns/1ps
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  skip_wload,
  input  logic [LEN_WIDTH-1:0]  m_len,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] o_base,
  output logic                  w_rd_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  a_rd_en,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [ARRAY_SIZE-1:0] weight_en,
  output logic                  go,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  busy,
  output logic                  done
);

  // Wide enough for the longest stream phase, M + 2N - 1.
  localparam int CW = LEN_WIDTH + $clog2(ARRAY_SIZE) + 2;
  localparam logic [CW-1:0] N_C   = CW'(ARRAY_SIZE);
  localparam logic [CW-1:0] TWO_N = CW'(2 * ARRAY_SIZE);

  typedef enum logic [1:0] {IDLE, WLOAD, STREAM, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  m_q, m_d;
  logic [ADDR_WIDTH-1:0] w_base_q, w_base_d, a_base_q, a_base_d, o_base_q, o_base_d;
  logic [CW-1:0]         last_q;

  logic                  w_rd_en_d, a_rd_en_d, go_d, o_wr_en_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0] w_addr_d, a_addr_d, o_addr_d;
  logic [ARRAY_SIZE-1:0] weight_en_d;

  assign last_q = CW'(m_q) + TWO_N - CW'(1);

  // Outputs are decoded from the *next* state and counter, then registered,
  // so in every cycle they reflect the state the controller is in.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    w_base_d    = w_base_q;
    a_base_d    = a_base_q;
    o_base_d    = o_base_q;
    w_rd_en_d   = 1'b0;
    w_addr_d    = '0;
    a_rd_en_d   = 1'b0;
    a_addr_d    = '0;
    weight_en_d = '0;
    go_d        = 1'b0;
    o_wr_en_d   = 1'b0;
    o_addr_d    = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d      = m_len;
          w_base_d = w_base;
          a_base_d = a_base;
          o_base_d = o_base;
          cnt_d    = '0;
          if (!skip_wload)        state_d = WLOAD;
          else if (m_len != '0)   state_d = STREAM;
          else                    state_d = DONE;
        end
      end
      WLOAD: begin
        if (cnt_q == N_C) begin
          cnt_d   = '0;
          state_d = (m_q != '0) ? STREAM : DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STREAM: begin
        if (cnt_q == last_q) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      WLOAD: begin
        busy_d = 1'b1;
        if (cnt_d < N_C) begin
          w_rd_en_d = 1'b1;
          w_addr_d  = w_base_d + ADDR_WIDTH'(cnt_d);
        end
        // Read latency of one cycle: row i is enabled the cycle after its issue.
        if (cnt_d != '0) weight_en_d = ARRAY_SIZE'(1) << (cnt_d - CW'(1));
      end
      STREAM: begin
        busy_d = 1'b1;
        if (cnt_d < CW'(m_d)) begin
          a_rd_en_d = 1'b1;
          a_addr_d  = a_base_d + ADDR_WIDTH'(cnt_d);
        end
        if (cnt_d != '0) go_d = 1'b1;
        if (cnt_d >= TWO_N) begin
          o_wr_en_d = 1'b1;
          o_addr_d  = o_base_d + ADDR_WIDTH'(cnt_d - TWO_N);
        end
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      o_base_q  <= '0;
      w_rd_en   <= 1'b0;
      w_addr    <= '0;
      a_rd_en   <= 1'b0;
      a_addr    <= '0;
      weight_en <= '0;
      go        <= 1'b0;
      o_wr_en   <= 1'b0;
      o_addr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      w_base_q  <= w_base_d;
      a_base_q  <= a_base_d;
      o_base_q  <= o_base_d;
      w_rd_en   <= w_rd_en_d;
      w_addr    <= w_addr_d;
      a_rd_en   <= a_rd_en_d;
      a_addr    <= a_addr_d;
      weight_en <= weight_en_d;
      go        <= go_d;
      o_wr_en   <= o_wr_en_d;
      o_addr    <= o_addr_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle expected outputs from a
// cycle-indexed schedule model, queued at start and compared every cycle.
`timescale 1ns/1ps
module tb_systolic_ctrl;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          skip_wload = 1'b0;
  logic [LW-1:0] m_len = '0;
  logic [AW-1:0] w_base = '0, a_base = '0, o_base = '0;

  logic          w_rd_en, a_rd_en, go, o_wr_en, busy, done;
  logic [AW-1:0] w_addr, a_addr, o_addr;
  logic [N-1:0]  weight_en;

  systolic_ctrl #(.ARRAY_SIZE(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .skip_wload(skip_wload), .m_len(m_len),
    .w_base(w_base), .a_base(a_base), .o_base(o_base),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .a_rd_en(a_rd_en), .a_addr(a_addr),
    .weight_en(weight_en), .go(go), .o_wr_en(o_wr_en), .o_addr(o_addr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          w_rd_en;
    logic [AW-1:0] w_addr;
    logic          a_rd_en;
    logic [AW-1:0] a_addr;
    logic [N-1:0]  weight_en;
    logic          go;
    logic          o_wr_en;
    logic [AW-1:0] o_addr;
    logic          busy;
    logic          done;
  } outs_t;

  typedef struct {
    string         name;
    bit            skip;
    int            m;
    logic [AW-1:0] wb, ab, ob;
    int            exp_done;  // hand-derived cycle of the done pulse
    int            exp_go;    // hand-derived number of go cycles
  } tile_t;

  outs_t act;
  assign act = {w_rd_en, w_addr, a_rd_en, a_addr, weight_en, go, o_wr_en, o_addr, busy, done};

  outs_t sb[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    done_at;
  int    go_cnt;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  function automatic int done_cycle(input tile_t t);
    int s = t.skip ? 1 : N + 2;
    if (t.m == 0) return s;
    return s + t.m + 2 * N;
  endfunction

  // Expected outputs in cycle c, where cycle 0 is the cycle start is sampled.
  function automatic outs_t model(input tile_t t, input int c);
    outs_t o = '0;
    int s  = t.skip ? 1 : N + 2;
    int dc = done_cycle(t);
    if (!t.skip) begin
      if (c >= 1 && c <= N) begin
        o.w_rd_en = 1'b1;
        o.w_addr  = t.wb + AW'(c - 1);
      end
      if (c >= 2 && c <= N + 1) o.weight_en = N'(1) << (c - 2);
    end
    if (t.m > 0) begin
      if (c >= s && c <= s + t.m - 1) begin
        o.a_rd_en = 1'b1;
        o.a_addr  = t.ab + AW'(c - s);
      end
      if (c >= s + 1 && c <= s + t.m + 2 * N - 1) o.go = 1'b1;
      if (c - s - 2 * N >= 0 && c - s - 2 * N < t.m) begin
        o.o_wr_en = 1'b1;
        o.o_addr  = t.ob + AW'(c - s - 2 * N);
      end
    end
    o.busy = (c >= 1 && c <= dc);
    o.done = (c == dc);
    return o;
  endfunction

  task automatic check_cycle(input string tag, input int c);
    outs_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty at cycle %0d", tag, c);
      return;
    end
    e = sb.pop_front();
    check($sformatf("%s c%0d", tag, c), 64'(act), 64'(e));
    check($sformatf("%s c%0d excl", tag, c),
          64'((|weight_en && go) || (w_rd_en && a_rd_en) || !$onehot0(weight_en)), 64'(0));
    if (done && done_at < 0) done_at = c;
    if (go) go_cnt++;
  endtask

  task automatic apply(input tile_t t);
    skip_wload = t.skip;
    m_len      = LW'(t.m);
    w_base     = t.wb;
    a_base     = t.ab;
    o_base     = t.ob;
  endtask

  // Called at a falling edge; that cycle becomes cycle 0 of the tile.
  task automatic run_tile(input tile_t t, input tile_t nxt, input bit b2b, input bit pulses);
    int da = done_cycle(t);
    int total;
    apply(t);
    start = 1'b1;
    for (int c = 1; c <= da + 1; c++) sb.push_back(model(t, c));
    if (b2b) for (int c = 1; c <= done_cycle(nxt) + 2; c++) sb.push_back(model(nxt, c));
    else     sb.push_back(model(t, da + 2));
    total   = sb.size();
    done_at = -1;
    go_cnt  = 0;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      check_cycle(t.name, c);
      if (b2b) begin
        if (c == 3) apply(nxt);
        if (c == da + 2) start = 1'b0;
      end else begin
        start = pulses && (c == 2 || c == da - 1 || c == da);
        if (start) begin
          skip_wload = 1'b1;
          m_len      = LW'($urandom_range(1, 9));
          a_base     = AW'($urandom);
        end
      end
    end
    start = 1'b0;
    check({t.name, " done_cycle"}, 64'(done_at), 64'(t.exp_done));
    if (!b2b) check({t.name, " go_cycles"}, 64'(go_cnt), 64'(t.exp_go));
  endtask

  tile_t tiles[6];
  tile_t b2b_second;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    tiles[0] = '{"full",      1'b0, 3, 16'h0010, 16'h0020, 16'h0040, 17, 10};
    tiles[1] = '{"skip",      1'b1, 2, 16'h0100, 16'h0200, 16'h0300, 11, 9};
    tiles[2] = '{"m0_load",   1'b0, 0, 16'h0050, 16'h0060, 16'h0070, 6, 0};
    tiles[3] = '{"m0_skip",   1'b1, 0, 16'h0050, 16'h0060, 16'h0070, 1, 0};
    tiles[4] = '{"wrap",      1'b0, 3, 16'hFFFE, 16'hFFFF, 16'hFFFE, 17, 10};
    tiles[5] = '{"skip_m1",   1'b1, 1, 16'h1234, 16'hABCD, 16'h5678, 10, 8};
    b2b_second = '{"b2b_2nd", 1'b1, 2, 16'h0000, 16'h0080, 16'h0090, 11, 9};

    // Reset held: everything zero.
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", 64'(act), 64'(0));
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_reset idle%0d", i), 64'(act), 64'(0));
    end

    foreach (tiles[i]) run_tile(tiles[i], tiles[i], 1'b0, 1'b0);

    // Hand check of address wrap on the activation side.
    apply(tiles[4]);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c >= 6) check($sformatf("wrap a_addr c%0d", c), 64'(a_addr), 64'(16'hFFFF + (c - 6)) & 64'hFFFF);
    end
    repeat (12) @(negedge clk);

    // Start held high across a whole tile: next tile accepted right after done.
    run_tile(tiles[0], b2b_second, 1'b1, 1'b0);
    // Start pulses mid-tile are ignored.
    run_tile(tiles[1], tiles[1], 1'b0, 1'b1);
    run_tile(tiles[0], tiles[0], 1'b0, 1'b1);

    // Reset in the middle of streaming.
    apply('{"mid_rst", 1'b1, 5, 16'h0, 16'h0300, 16'h0400, 0, 0});
    start = 1'b1;
    for (int c = 1; c <= 4; c++) sb.push_back(model('{"mid_rst", 1'b1, 5, 16'h0, 16'h0300, 16'h0400, 0, 0}, c));
    done_at = -1;
    go_cnt  = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_cycle("mid_rst", c);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("mid_rst same_cycle", 64'(act), 64'(0));
    @(negedge clk);
    check("mid_rst held", 64'(act), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst released", 64'(act), 64'(0));
    run_tile(tiles[0], tiles[0], 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
